// File: rtl/upc_loop_event_recorder_if.sv
`default_nettype none
// ============================================================================
// Module      : upc_loop_event_recorder_if
// Description : Record drain port (valid/ready plus record fields).
// Revision    : 1.0
// ============================================================================
interface upc_loop_event_recorder_if #(
  parameter int TS_W  = 32,
  parameter int CNT_W = 16
);
  logic             rec_valid;
  logic             rec_ready;
  logic [TS_W-1:0]  rec_start_ts;
  logic [TS_W-1:0]  rec_end_ts;
  logic [CNT_W-1:0] rec_iter_cnt;
  logic [CNT_W-1:0] rec_ii_max;
  logic             rec_aborted;

  modport master (
    output rec_valid, rec_start_ts, rec_end_ts, rec_iter_cnt, rec_ii_max, rec_aborted,
    input  rec_ready
  );

  modport slave (
    input  rec_valid, rec_start_ts, rec_end_ts, rec_iter_cnt, rec_ii_max, rec_aborted,
    output rec_ready
  );
endinterface
`default_nettype wire

// File: rtl/upc_loop_event_recorder.sv
`default_nettype none
// ============================================================================
// Module      : upc_loop_event_recorder
// Description : Compresses each pipelined-loop execution into one record
//               (timestamps, iteration count, worst II, abort) behind a FIFO.
// Revision    : 1.0
// ============================================================================
module upc_loop_event_recorder #(
  parameter int TS_W       = 32,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  wire                       clock,
  input  wire                       reset,
  input  wire                       loop_start,
  input  wire                       loop_done,
  input  wire                       iter_start,
  input  wire                       finish,
  upc_loop_event_recorder_if.master rec,
  output logic [CNT_W-1:0]          drop_cnt,
  output logic                      busy
);

  localparam int               c_ptr_w   = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [c_ptr_w:0] c_depth   = (c_ptr_w+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [TS_W-1:0]  start_ts;
    logic [TS_W-1:0]  end_ts;
    logic [CNT_W-1:0] iter_cnt;
    logic [CNT_W-1:0] ii_max;
    logic             aborted;
  } rec_t;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [TS_W-1:0]  r_ts;
  logic [TS_W-1:0]  r_start_ts, w_start_nxt;
  logic [TS_W-1:0]  r_last_ts, w_last_nxt, w_last_upd;
  logic [CNT_W-1:0] r_iter_cnt, w_cnt_nxt, w_cnt_upd, w_cnt_inc;
  logic [CNT_W-1:0] r_ii_max, w_ii_nxt, w_ii_upd, w_interval;
  logic [TS_W-1:0]  w_delta;
  logic             w_push;
  rec_t             w_rec;

  rec_t             r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wptr, r_rptr;
  logic [c_ptr_w:0]   r_count;
  logic [CNT_W-1:0]   r_drop_cnt;
  logic             w_valid, w_pop, w_full, w_wr;
  rec_t             w_head;

  // Per-iteration bookkeeping, applied only while running
  assign w_cnt_inc  = (r_iter_cnt == c_cnt_max) ? r_iter_cnt : r_iter_cnt + CNT_W'(1);
  assign w_delta    = r_ts - r_last_ts;
  assign w_interval = (w_delta > TS_W'(c_cnt_max)) ? c_cnt_max : w_delta[CNT_W-1:0];
  assign w_cnt_upd  = iter_start ? w_cnt_inc : r_iter_cnt;
  assign w_ii_upd   = (iter_start && (r_iter_cnt != '0) && (w_interval > r_ii_max))
                      ? w_interval : r_ii_max;
  assign w_last_upd = iter_start ? r_ts : r_last_ts;

  always_comb begin
    w_state_nxt      = r_state;
    w_start_nxt      = r_start_ts;
    w_cnt_nxt        = r_iter_cnt;
    w_ii_nxt         = r_ii_max;
    w_last_nxt       = r_last_ts;
    w_push           = 1'b0;
    w_rec.start_ts   = r_start_ts;
    w_rec.end_ts     = r_ts;
    w_rec.iter_cnt   = w_cnt_upd;
    w_rec.ii_max     = w_ii_upd;
    w_rec.aborted    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (loop_start && !finish) begin
          w_state_nxt = S_RUN;
          w_start_nxt = r_ts;
          w_cnt_nxt   = iter_start ? CNT_W'(1) : '0;
          w_ii_nxt    = '0;
          w_last_nxt  = r_ts;
        end
      end
      S_RUN: begin
        w_cnt_nxt  = w_cnt_upd;
        w_ii_nxt   = w_ii_upd;
        w_last_nxt = w_last_upd;
        if (loop_done) begin
          w_push = 1'b1;
          // ap_start still high: next transaction opens on the following cycle
          if (loop_start) begin
            w_start_nxt = r_ts + TS_W'(1);
            w_cnt_nxt   = '0;
            w_ii_nxt    = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (finish) begin
          w_push        = 1'b1;
          w_rec.aborted = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ts       <= '0;
      r_start_ts <= '0;
      r_last_ts  <= '0;
      r_iter_cnt <= '0;
      r_ii_max   <= '0;
    end else begin
      r_ts       <= r_ts + TS_W'(1);
      r_start_ts <= w_start_nxt;
      r_last_ts  <= w_last_nxt;
      r_iter_cnt <= w_cnt_nxt;
      r_ii_max   <= w_ii_nxt;
    end
  end

  // Record FIFO: a push into a full FIFO survives only if the head leaves this cycle
  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == c_depth);
  assign w_pop   = w_valid && rec.rec_ready;
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_head  = r_mem[r_rptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= w_rec;
        r_wptr        <= r_wptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_ptr_w'(1);
      end
      if (w_wr && !w_pop) begin
        r_count <= r_count + (c_ptr_w+1)'(1);
      end else if (!w_wr && w_pop) begin
        r_count <= r_count - (c_ptr_w+1)'(1);
      end
      if (w_push && !w_wr && (r_drop_cnt != c_cnt_max)) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  assign rec.rec_valid    = w_valid;
  assign rec.rec_start_ts = w_head.start_ts;
  assign rec.rec_end_ts   = w_head.end_ts;
  assign rec.rec_iter_cnt = w_head.iter_cnt;
  assign rec.rec_ii_max   = w_head.ii_max;
  assign rec.rec_aborted  = w_head.aborted;
  assign drop_cnt         = r_drop_cnt;
  assign busy             = (r_state == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_upc_loop_event_recorder.sv
`default_nettype none
// ============================================================================
// Module      : tb_upc_loop_event_recorder
// Description : Directed scoreboard bench for upc_loop_event_recorder.
// Revision    : 1.0
// ============================================================================
module tb_upc_loop_event_recorder;

  typedef struct packed {
    logic [31:0] start_ts;
    logic [31:0] end_ts;
    logic [15:0] iter_cnt;
    logic [15:0] ii_max;
    logic        aborted;
  } rec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        loop_start = 1'b0;
  logic        loop_done = 1'b0;
  logic        iter_start = 1'b0;
  logic        finish = 1'b0;
  logic [15:0] drop_cnt;
  logic        busy;
  logic [31:0] tb_ts;
  int          checks = 0;
  int          failures = 0;
  rec_t        expq[$];
  rec_t        mon_got, mon_want;

  upc_loop_event_recorder_if #(.TS_W(32), .CNT_W(16)) rec_if ();

  upc_loop_event_recorder #(.TS_W(32), .CNT_W(16), .FIFO_DEPTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .loop_start (loop_start),
    .loop_done  (loop_done),
    .iter_start (iter_start),
    .finish     (finish),
    .rec        (rec_if),
    .drop_cnt   (drop_cnt),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // Reference timestamp: counts edges since reset release
  always @(posedge clock or posedge reset) begin
    if (reset) tb_ts <= '0;
    else       tb_ts <= tb_ts + 32'd1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (ts=%0d)", name, act, exp, tb_ts);
    end
  endtask

  task automatic at_ts(input logic [31:0] n);
    int guard = 0;
    while (tb_ts != n) begin
      @(posedge clock); #1;
      guard++;
      if (guard > 400) begin
        failures++;
        $display("FAIL at_ts timeout actual=%0d required=%0d", tb_ts, n);
        $fatal(1, "stimulus timeline lost");
      end
    end
  endtask

  task automatic set(input logic [31:0] n, input logic ls, input logic ld,
                     input logic is, input logic fin, input logic rdy);
    at_ts(n);
    loop_start       = ls;
    loop_done        = ld;
    iter_start       = is;
    finish           = fin;
    rec_if.rec_ready = rdy;
  endtask

  task automatic expect_rec(input logic [31:0] s, input logic [31:0] e,
                            input logic [15:0] c, input logic [15:0] ii, input logic ab);
    rec_t r;
    r.start_ts = s; r.end_ts = e; r.iter_cnt = c; r.ii_max = ii; r.aborted = ab;
    expq.push_back(r);
  endtask

  // Monitor: every accepted record is compared with the oldest expectation
  always @(negedge clock) begin
    if (!reset && rec_if.rec_valid && rec_if.rec_ready) begin
      mon_got.start_ts = rec_if.rec_start_ts;
      mon_got.end_ts   = rec_if.rec_end_ts;
      mon_got.iter_cnt = rec_if.rec_iter_cnt;
      mon_got.ii_max   = rec_if.rec_ii_max;
      mon_got.aborted  = rec_if.rec_aborted;
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL record_unexpected actual start=%0d end=%0d cnt=%0d ii=%0d ab=%0d required none",
                 mon_got.start_ts, mon_got.end_ts, mon_got.iter_cnt, mon_got.ii_max, mon_got.aborted);
      end else begin
        mon_want = expq.pop_front();
        if (mon_got !== mon_want) begin
          failures++;
          $display("FAIL record actual start=%0d end=%0d cnt=%0d ii=%0d ab=%0d required start=%0d end=%0d cnt=%0d ii=%0d ab=%0d",
                   mon_got.start_ts, mon_got.end_ts, mon_got.iter_cnt, mon_got.ii_max, mon_got.aborted,
                   mon_want.start_ts, mon_want.end_ts, mon_want.iter_cnt, mon_want.ii_max, mon_want.aborted);
        end
      end
    end
  end

  initial begin
    rec_if.rec_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_valid", rec_if.rec_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_drop", drop_cnt, 0);
    @(negedge clock); reset = 1'b0;
    #1;
    chk("reset_start_ts", rec_if.rec_start_ts, 0);
    chk("reset_iter_cnt", rec_if.rec_iter_cnt, 0);

    // Single run: start 5, iterations 6/8/10, done 12
    set(5, 1,0,0,0,0); set(6, 0,0,1,0,0); set(7, 0,0,0,0,0);
    set(8, 0,0,1,0,0); set(9, 0,0,0,0,0); set(10, 0,0,1,0,0); set(11, 0,0,0,0,0);
    chk("t1_busy_run", busy, 1);
    set(12, 0,1,0,0,0); expect_rec(5, 12, 3, 2, 0);
    chk("t1_valid_before", rec_if.rec_valid, 0);
    set(13, 0,0,0,0,0);
    chk("t1_valid_after", rec_if.rec_valid, 1);
    chk("t1_busy_after", busy, 0);
    rec_if.rec_ready = 1'b1;

    // Back-to-back with ap_start held
    set(15, 1,0,0,0,1); set(16, 1,0,1,0,1); set(17, 1,0,0,0,1);
    set(19, 1,0,1,0,1); set(20, 1,1,1,0,1); expect_rec(15, 20, 3, 3, 0);
    set(21, 1,0,0,0,1);
    chk("t2_busy_b2b", busy, 1);
    set(22, 1,0,1,0,1); set(23, 1,0,0,0,1); set(26, 1,0,1,0,1); set(27, 1,0,0,0,1);
    set(28, 0,1,1,0,1); expect_rec(21, 28, 3, 4, 0);
    set(29, 0,0,0,0,1);
    chk("t2_busy_end", busy, 0);

    // Overflow: 6 transactions into a 4-deep FIFO with no consumer
    set(30, 0,0,0,0,0);
    for (int k = 0; k < 6; k++) begin
      set(32 + 4*k, 1,0,0,0,0);
      set(33 + 4*k, 0,0,1,0,0);
      set(34 + 4*k, 0,1,0,0,0);
      if (k < 4) expect_rec(32 + 4*k, 34 + 4*k, 1, 0, 0);
      set(35 + 4*k, 0,0,0,0,0);
      if (k == 4) chk("t3_head_held_mid", rec_if.rec_start_ts, 32);
    end
    set(56, 0,0,0,0,0);
    chk("t3_drop_cnt", drop_cnt, 2);
    chk("t3_head_start", rec_if.rec_start_ts, 32);
    chk("t3_head_end", rec_if.rec_end_ts, 34);
    set(57, 0,0,0,0,1);
    set(60, 0,0,0,0,1);
    chk("t3_valid_last", rec_if.rec_valid, 1);
    set(61, 0,0,0,0,1);
    chk("t3_valid_drained", rec_if.rec_valid, 0);

    // Full FIFO with a pop coinciding with the push
    set(62, 0,0,0,0,0);
    for (int k = 0; k < 4; k++) begin
      set(64 + 3*k, 1,0,0,0,0);
      set(65 + 3*k, 0,1,0,0,0);
      expect_rec(64 + 3*k, 65 + 3*k, 0, 0, 0);
      set(66 + 3*k, 0,0,0,0,0);
    end
    set(76, 1,0,0,0,0);
    set(77, 0,1,0,0,1); expect_rec(76, 77, 0, 0, 0);
    set(78, 0,0,0,0,0);
    chk("t4_drop_unchanged", drop_cnt, 2);
    chk("t4_head_after_pop", rec_if.rec_start_ts, 67);
    set(80, 0,0,0,0,1);
    set(83, 0,0,0,0,1);
    chk("t4_valid_4th", rec_if.rec_valid, 1);
    set(84, 0,0,0,0,1);
    chk("t4_valid_drained", rec_if.rec_valid, 0);

    // finish aborts a run; start ignored while finish held
    set(90, 1,0,0,0,1); set(91, 0,0,1,0,1); set(92, 0,0,0,0,1);
    set(94, 0,0,1,0,1); set(95, 0,0,0,0,1);
    set(96, 0,0,0,1,1); expect_rec(90, 96, 2, 3, 1);
    set(98, 1,0,0,1,1); set(99, 1,0,0,1,1);
    chk("t5_start_blocked", busy, 0);
    set(100, 0,0,0,0,1);
    // done and finish together: done wins
    set(102, 1,0,0,0,1); set(103, 0,0,1,0,1); set(104, 0,0,0,0,1);
    set(105, 0,1,0,1,1); expect_rec(102, 105, 1, 0, 0);
    set(106, 0,0,0,0,1);
    // done while idle is ignored
    set(108, 0,1,0,0,1); set(109, 0,0,0,0,1); set(110, 0,0,0,0,1);
    chk("t5_idle_done_drop", drop_cnt, 2);
    chk("t5_idle_done_busy", busy, 0);

    // Reset mid-run with two records queued
    set(112, 1,0,0,0,0); set(113, 0,1,0,0,0); expect_rec(112, 113, 0, 0, 0);
    set(114, 0,0,0,0,0); set(115, 1,0,0,0,0); set(116, 0,1,0,0,0); expect_rec(115, 116, 0, 0, 0);
    set(117, 0,0,0,0,0); set(118, 1,0,0,0,0); set(120, 1,0,0,0,0);
    chk("t6_valid_pre", rec_if.rec_valid, 1);
    chk("t6_busy_pre", busy, 1);
    #2;
    reset = 1'b1;
    loop_start = 1'b0;
    #1;
    chk("t6_valid_async", rec_if.rec_valid, 0);
    chk("t6_busy_async", busy, 0);
    chk("t6_drop_async", drop_cnt, 0);
    expq.delete();
    @(negedge clock); reset = 1'b0; rec_if.rec_ready = 1'b1;
    set(2, 0,0,0,0,1);
    chk("t6_no_stale", rec_if.rec_valid, 0);
    // Timestamp restarted from 0: finish mid-run at ts=9
    set(3, 1,0,0,0,1); set(4, 0,0,1,0,1); set(5, 0,0,0,0,1);
    set(6, 0,0,1,0,1); set(7, 0,0,0,0,1);
    set(9, 0,0,0,1,1); expect_rec(3, 9, 2, 2, 1);
    set(10, 0,0,0,0,1);

    for (int g = 0; g < 20 && expq.size() != 0; g++) @(posedge clock);
    repeat (4) @(posedge clock);
    #1;
    chk("scoreboard_drained", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/upc_loop_event_recorder.md
Name: upc_loop_event_recorder

Overview:
Synthesizable per-transaction profiler that sits directly upstream of the cosim CSV dumpers. It observes a pipelined loop's handshake and iteration events and compresses each loop execution into one record: start/end timestamp, iteration count, worst initiation interval and an abort flag. Records are queued in a small FIFO and drained over a valid/ready port, so the dump side can consume them at its own pace.

Parameters:
TS_W, 32, width of free-running timestamp and record timestamps
CNT_W, 16, width of iteration count, II and drop counters
FIFO_DEPTH, 4, record FIFO entries; power of two, >= 2

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-high reset
loop_start  in  1  loop ap_start, level
loop_done  in  1  loop ap_done_int, single-cycle pulse
iter_start  in  1  qualified iteration-start event: start state & iter0 enable & !subdone block
finish  in  1  simulation/test finish request, level
rec_valid  out  1  FIFO head holds a record
rec_ready  in  1  consumer accepts head
rec_start_ts  out  TS_W  ts at transaction start
rec_end_ts  out  TS_W  ts at done or abort
rec_iter_cnt  out  CNT_W  iterations started, saturating
rec_ii_max  out  CNT_W  max cycles between consecutive iter_start, saturating, 0 if <2 iterations
rec_aborted  out  1  record closed by finish, not loop_done
drop_cnt  out  CNT_W  records lost to full FIFO, saturating
busy  out  1  FSM in RUN

Behaviour:
- Reset (async assert, sync release): ts=0, FSM=IDLE, FIFO empty, all outputs 0, drop_cnt=0.
- ts increments by 1 every clock edge out of reset and wraps modulo 2^TS_W. Every event is stamped with the current ts register value.
- The module is a flow-through recorder. It never backpressures the monitored loop.
- FSM, two states:
  - IDLE: loop_start=1 & finish=0 -> RUN. Capture start_ts=ts, iter_cnt=0, ii_max=0. An iter_start in that same cycle counts as iteration 1, with last_ts=ts.
  - RUN, on iter_start: iter_cnt++ (saturating at all-ones).
    - If iter_cnt was >=1 before the increment: interval=ts-last_ts (modulo TS_W, clamped to all-ones of CNT_W), and ii_max=max(ii_max, interval).
    - last_ts=ts.
  - RUN, on loop_done: iter_start in the same cycle is counted first. Close the record with end_ts=ts and aborted=0, then push.
    - If loop_start=1 that cycle, stay in RUN and open the next transaction with start_ts=ts+1, i.e. the next cycle. This is back-to-back ap_start held high.
    - Otherwise go to IDLE.
  - RUN, finish=1 and no loop_done: close with end_ts=ts and aborted=1, push, go to IDLE. If loop_done and finish occur together, loop_done wins (aborted=0).
  - IDLE with finish=1: no transitions, no pushes.
  - loop_done in IDLE: ignored. It produces no record and does not change drop_cnt.
- FIFO and output port:
  - Show-ahead. Outputs are driven from registered head storage.
  - Push on the close cycle. rec_valid rises on the next edge, so record latency is 1 cycle after loop_done.
  - Pop when rec_valid & rec_ready.
  - Push while full with a pop in the same cycle: accepted, and the count stays FIFO_DEPTH.
  - Push while full without a pop: record discarded, drop_cnt++ (saturating).
  - Push and pop on an empty FIFO cannot coincide, because rec_valid=0.
  - Record fields are stable while rec_valid=1 & rec_ready=0.
- busy = (FSM==RUN).
- Reset mid-RUN: the in-flight transaction and all queued records are discarded, and no record is emitted.

Test Plan:
- Single run: loop_start at ts=5; iter_start at ts=6,8,10; loop_done at ts=12 -> rec_valid=1 at ts=13 with start=5, end=12, iter_cnt=3, ii_max=2, aborted=0; busy low from ts=13.
- Back-to-back: loop_start held, first loop_done at ts=20 -> record1 end=20; second transaction start=21; iter_start coincident with the 2nd done is included in its iter_cnt.
- Overflow: rec_ready=0, 6 transactions with FIFO_DEPTH=4 -> 4 records held unchanged, drop_cnt=2. Then rec_ready=1 -> 4 records pop in order, one per cycle; rec_valid falls after the 4th.
- Full with simultaneous pop: FIFO full, loop_done in the same cycle as rec_ready=1 -> new record accepted, drop_cnt unchanged, count stays 4.
- finish mid-run: start at ts=3, 2 iterations, finish at ts=9 -> record end=9, aborted=1, iter_cnt=2. Later loop_start ignored while finish=1. With finish and loop_done together: aborted=0.
- Reset mid-run with 2 records queued: assert reset asynchronously -> rec_valid, busy, drop_cnt are 0 immediately; after release, ts restarts at 0 and no stale record appears.
